// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised synchronous FIFO with show-ahead/registered read, thresholds and debug stats
module sync_fifo_flex #(
  parameter int DWIDTH   = 136,
  parameter int DEPTH    = 16,
  parameter bit FWFT     = 1,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  input  logic              flush,
  input  logic              clr_stats,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     hwm,
  output logic              overflow,
  output logic              underflow
);
  localparam int PW = $clog2(DEPTH);
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, r_hwm, w_next_count;
  logic r_overflow, r_underflow, w_rd_ok, w_wr_ok;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign empty        = r_count == '0;
  assign full         = r_count == CW'(DEPTH);
  assign almost_empty = r_count <= CW'(AE_LEVEL);
  assign almost_full  = r_count >= CW'(AF_LEVEL);
  assign count        = r_count;
  assign hwm          = r_hwm;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign w_rd_ok      = !flush && rd_en && !empty;
  assign w_wr_ok      = !flush && wr_en && (!full || w_rd_ok);
  assign w_next_count = flush ? '0 : r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_hwm       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= flush ? '0 : w_wr_ok ? inc(r_wr_ptr) : r_wr_ptr;
      r_rd_ptr    <= flush ? '0 : w_rd_ok ? inc(r_rd_ptr) : r_rd_ptr;
      r_count     <= w_next_count;
      r_hwm       <= (clr_stats || w_next_count > r_hwm) ? w_next_count : r_hwm;
      r_overflow  <= (!flush && wr_en && full && !w_rd_ok) || (r_overflow && !clr_stats);
      r_underflow <= (!flush && rd_en && empty) || (r_underflow && !clr_stats);
    end
  always_ff @(posedge clk)
    if (w_wr_ok) r_mem[r_wr_ptr] <= wdata;
  if (FWFT) begin : g_fwft
    assign rdata  = r_mem[r_rd_ptr];
    assign rvalid = !empty;
  end else begin : g_reg
    logic [DWIDTH-1:0] r_rdata;
    logic r_rvalid;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_rd_ok;
        if (w_rd_ok) r_rdata <= r_mem[r_rd_ptr];
      end
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
  end
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Parametrised successor to the OpenDVS synchronous event FIFO, buffering DWIDTH-bit event words between the event encoder and the readout/serialiser.
- Adds the following over the previous generation:
  - non-power-of-two depth;
  - full-range occupancy count;
  - a selectable output mode: show-ahead or registered;
  - programmable almost-full and almost-empty flags;
  - a read-and-write-when-full pass-through;
  - a synchronous flush;
  - sticky overflow/underflow flags and a high-water mark, for debug readout.

Parameters:
DWIDTH, 136, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer, not restricted to powers of two)
FWFT, 1, 1 = show-ahead (rdata valid whenever !empty); 0 = registered read (rdata valid one cycle after an accepted read)
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
CW, $clog2(DEPTH+1), derived count width; not to be overridden

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
wdata  input  DWIDTH  write data
rd_en  input  1  read request
rdata  output  DWIDTH  read data
rvalid  output  1  rdata qualifier (FWFT=1: equals !empty; FWFT=0: one-cycle pulse)
flush  input  1  synchronous clear of contents
clr_stats  input  1  synchronous clear of overflow, underflow, hwm
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_empty  output  1  count <= AE_LEVEL
almost_full  output  1  count >= AF_LEVEL
count  output  CW  current occupancy, 0..DEPTH
hwm  output  CW  maximum count since reset/clr_stats
overflow  output  1  sticky: write dropped
underflow  output  1  sticky: read on empty

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr, rd_ptr, count, hwm = 0; overflow, underflow = 0; rvalid = 0; rdata = 0 in FWFT=0.
  - Flags after reset: empty=1, full=0, almost_empty=1, almost_full=0.
  - Array contents are not reset.
- Pointers:
  - Range 0..DEPTH-1; wrap from DEPTH-1 to 0 explicitly.
  - No reliance on binary overflow.
- Read acceptance: rd_ok = rd_en && !empty.
- Write acceptance: wr_ok = wr_en && (!full || rd_ok). Write on full is accepted only when a read is accepted in the same cycle; count then stays DEPTH.
- Count update: count += wr_ok - rd_ok. Simultaneous wr_ok and rd_ok leaves count unchanged.
- Write on empty with rd_en in the same cycle: the write is accepted, the read is rejected, count becomes 1, underflow is set.
- Data path, FWFT=1:
  - rdata = mem[rd_ptr] combinationally; rvalid = !empty.
  - rd_en pops the word currently presented.
  - Latency from write to visible rdata: 1 cycle (the word is visible the cycle after wr_ok).
- Data path, FWFT=0:
  - On rd_ok, rdata <= mem[rd_ptr] and rvalid <= 1 next cycle; otherwise rvalid <= 0 and rdata holds its last value.
  - Back-to-back rd_en yields one word per cycle.
- Flags: empty, full, almost_empty, almost_full and count are all decoded from the registered count, so none combinationally depends on wr_en/rd_en.
- overflow: set when wr_en && full && !rd_ok.
- underflow: set when rd_en && empty.
- Sticky behaviour: overflow and underflow hold until clr_stats or reset.
- hwm: hwm <= max(hwm, next count) every cycle.
- clr_stats:
  - Clears overflow, underflow and hwm to 0 next cycle.
  - A set event in the same cycle wins: the flag ends at 1, and hwm loads the next count.
- flush:
  - Next cycle: pointers = 0, count = 0, rvalid = 0.
  - Overrides wr_en/rd_en in the same cycle (no write, no read, no error flags set).
  - Does not clear hwm or the sticky flags.
- Out of scope: no combinational path from wdata to rdata. Pass-through when empty is not supported; a written word appears only after the write edge.

Test Plan:
- Fill/drain, DEPTH=5 (non-power-of-two): write 0xA0..0xA4 → full=1, count=5; then a 6th write → overflow=1, count stays 5; read 5 → order 0xA0..0xA4, empty=1; wrap exercised twice with no corruption.
- Full pass-through: with full=1, assert wr_en+rd_en with wdata=0xBEEF → old head popped, count stays 5, overflow=0, 0xBEEF read out last.
- FWFT=0, DEPTH=16: write 0x11, 0x22; rd_en for 2 cycles → rvalid high for 2 cycles starting 1 cycle after the first rd_en, with rdata 0x11 then 0x22; rd_en on empty → rvalid=0, underflow=1.
- Thresholds, AF_LEVEL=14, AE_LEVEL=2: step count 0→16→0 → almost_empty=1 for count<=2, almost_full=1 for count>=14, hwm=16 at the end; clr_stats → hwm=0 (count 0).
- Flush mid-operation: count=7, then flush with wr_en=1 → next cycle count=0, empty=1, hwm stays 7; the next write is read back at ptr 0.
- Async reset mid-stream: rst_n low between edges with count=9 → outputs reset immediately without a clock; after release, the first write and read work normally.
